xgmii_rx_checker: RTL and testbench

XGMII_RX_CHECKER -- requirements
Module: xgmii_rx_checker

---
 rtl/xgmii_pkg.sv | 25 ++
 rtl/xgmii_word_classify.sv | 46 ++++
 rtl/xgmii_rx_checker.sv | 111 +++++++++++
 tb/tb_xgmii_rx_checker.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xgmii_pkg.sv
// xgmii_pkg: default XGMII codes, checker state/error/word-class types and a saturating length add
package xgmii_pkg;
  localparam logic [7:0] DEF_IDLE_CODE = 8'h07;
  localparam logic [7:0] DEF_START_CODE = 8'hFB;
  localparam logic [7:0] DEF_TERM_CODE = 8'hFD;
  localparam logic [7:0] DEF_DATA_BYTE = 8'hAA;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'b00;
  localparam state_t S_PAYLOAD = 2'b01;
  localparam state_t S_DROP = 2'b10;
  typedef enum logic [2:0] {
    ERR_NONE = 3'd0,
    ERR_BAD_IDLE = 3'd1,
    ERR_UNEXP_START = 3'd2,
    ERR_BAD_CTRL = 3'd3,
    ERR_OVERSIZE = 3'd4,
    ERR_PATTERN = 3'd5
  } err_code_t;
  typedef enum logic [2:0] {W_IDLE, W_START, W_DATA, W_TERM, W_BAD} word_class_t;
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/xgmii_word_classify.sv
// xgmii_word_classify: classifies one XGMII word, finds the terminate lane and checks payload bytes
module xgmii_word_classify import xgmii_pkg::*; #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter logic [7:0] IDLE_CODE = DEF_IDLE_CODE,
  parameter logic [7:0] START_CODE = DEF_START_CODE,
  parameter logic [7:0] TERM_CODE = DEF_TERM_CODE,
  parameter logic [7:0] DATA_BYTE = DEF_DATA_BYTE,
  localparam int PW = $clog2(CTRL_WIDTH)
) (
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic [CTRL_WIDTH-1:0] rx_ctrl,
  output word_class_t           word_class,
  output logic [PW-1:0]         term_lane,
  output logic                  pay_ok
);
  logic is_idle, is_start, is_term, found, data_ok, start_ok, term_ok;
  // Terminate lane is the lowest ctrl lane; lanes below it are data, lanes above must be idle
  always_comb begin
    is_idle = &rx_ctrl;
    found = 1'b0;
    term_lane = '0;
    data_ok = 1'b1;
    start_ok = 1'b1;
    term_ok = 1'b1;
    is_term = 1'b1;
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      is_idle = is_idle && (rx_data[8*i+:8] == IDLE_CODE);
      data_ok = data_ok && (rx_data[8*i+:8] == DATA_BYTE);
      if (i > 0) start_ok = start_ok && (rx_data[8*i+:8] == DATA_BYTE);
      if (rx_ctrl[i] && !found) begin
        found = 1'b1;
        term_lane = PW'(i);
      end
    end
    for (int i = 0; i < CTRL_WIDTH; i++) begin
      if (PW'(i) < term_lane) term_ok = term_ok && (rx_data[8*i+:8] == DATA_BYTE);
      else if (PW'(i) == term_lane) is_term = is_term && (rx_data[8*i+:8] == TERM_CODE);
      else is_term = is_term && rx_ctrl[i] && (rx_data[8*i+:8] == IDLE_CODE);
    end
    is_term = is_term && found;
    is_start = (rx_ctrl == CTRL_WIDTH'(1)) && (rx_data[7:0] == START_CODE);
    word_class = is_idle ? W_IDLE : is_start ? W_START : ~|rx_ctrl ? W_DATA : is_term ? W_TERM : W_BAD;
    pay_ok = (word_class == W_START) ? start_ok : (word_class == W_TERM) ? term_ok : data_ok;
  end
endmodule

// File: rtl/xgmii_rx_checker.sv
// xgmii_rx_checker: XGMII receive frame checker; payload byte checking enabled by XGMII_RX_PATTERN_CHECK_EN
module xgmii_rx_checker import xgmii_pkg::*; #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = 8,
  parameter logic [7:0] IDLE_CODE = DEF_IDLE_CODE,
  parameter logic [7:0] START_CODE = DEF_START_CODE,
  parameter logic [7:0] TERM_CODE = DEF_TERM_CODE,
  parameter logic [7:0] DATA_BYTE = DEF_DATA_BYTE,
  parameter int MAX_WORDS = 32
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
  output logic                  o_frame_done,
  output logic [15:0]           o_frame_len,
  output logic                  o_err,
  output logic [2:0]            o_err_code,
  output logic                  o_in_frame,
  output logic [31:0]           o_good_cnt,
  output logic [31:0]           o_bad_cnt
);
  localparam int PW = $clog2(CTRL_WIDTH);
  localparam int WW = $clog2(MAX_WORDS + 1);
`ifdef XGMII_RX_PATTERN_CHECK_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif
  state_t state;
  logic [15:0] len;
  logic [WW-1:0] wcnt;
  logic pat, pay_ok, mis;
  word_class_t wc;
  logic [PW-1:0] tp;
  xgmii_word_classify #(
    .DATA_WIDTH(DATA_WIDTH),
    .CTRL_WIDTH(CTRL_WIDTH),
    .IDLE_CODE(IDLE_CODE),
    .START_CODE(START_CODE),
    .TERM_CODE(TERM_CODE),
    .DATA_BYTE(DATA_BYTE)
  ) u_classify (
    .rx_data(i_rx_data),
    .rx_ctrl(i_rx_ctrl),
    .word_class(wc),
    .term_lane(tp),
    .pay_ok(pay_ok)
  );
  assign mis = PAT_EN && !pay_ok;
  assign o_in_frame = state[0];
  // Frame FSM with length/word tracking, result pulses, held error code and frame counters
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      len <= '0;
      wcnt <= '0;
      pat <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_len <= '0;
      o_err <= 1'b0;
      o_err_code <= '0;
      o_good_cnt <= '0;
      o_bad_cnt <= '0;
    end else begin
      o_frame_done <= 1'b0;
      o_err <= 1'b0;
      if (wc == W_START) begin
        state <= S_PAYLOAD;
        len <= 16'd7;
        wcnt <= '0;
        pat <= mis;
        if (state == S_PAYLOAD) begin
          o_err <= 1'b1;
          o_err_code <= ERR_UNEXP_START;
          o_bad_cnt <= o_bad_cnt + 32'd1;
        end
      end else if (state == S_PAYLOAD) begin
        if (wc == W_TERM) begin
          state <= S_IDLE;
          o_frame_len <= sat_add16(len, 16'(tp));
          if (pat || mis) begin
            o_err <= 1'b1;
            o_err_code <= ERR_PATTERN;
            o_bad_cnt <= o_bad_cnt + 32'd1;
          end else begin
            o_frame_done <= 1'b1;
            o_good_cnt <= o_good_cnt + 32'd1;
          end
        end else if (wc == W_DATA && wcnt != WW'(MAX_WORDS)) begin
          len <= sat_add16(len, 16'd8);
          wcnt <= wcnt + 1'b1;
          pat <= pat || mis;
        end else begin
          state <= S_DROP;
          o_err <= 1'b1;
          o_err_code <= (wc == W_DATA) ? ERR_OVERSIZE : ERR_BAD_CTRL;
          o_bad_cnt <= o_bad_cnt + 32'd1;
        end
      end else if (state == S_DROP) begin
        if (wc == W_IDLE) state <= S_IDLE;
      end else begin
        state <= S_IDLE;
        if (wc != W_IDLE) begin
          o_err <= 1'b1;
          o_err_code <= ERR_BAD_IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_xgmii_rx_checker.sv
// tb_xgmii_rx_checker: table, directed and randomized checks against a byte-level reference model
module tb_xgmii_rx_checker;
  localparam logic [7:0] IC = 8'h07;
  localparam logic [7:0] SC = 8'hFB;
  localparam logic [7:0] TC = 8'hFD;
  localparam logic [7:0] DB = 8'hAA;
  localparam int MAXW = 32;
`ifdef XGMII_RX_PATTERN_CHECK_EN
  localparam bit PAT_EN = 1'b1;
`else
  localparam bit PAT_EN = 1'b0;
`endif
  localparam int K_IDLE = 0, K_START = 1, K_DATA = 2, K_TERM = 3, K_BAD = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] rx_data = {8{IC}};
  logic [7:0] rx_ctrl = 8'hFF;
  logic frame_done, err, in_frame;
  logic [15:0] frame_len;
  logic [2:0] err_code;
  logic [31:0] good_cnt, bad_cnt;
  int n_cmp = 0;
  int n_bad = 0;
  int m_mode, m_len, m_words;
  bit m_flag, m_done, m_err;
  logic [2:0] m_code;
  logic [15:0] m_flen;
  logic [31:0] m_good, m_bad;
  typedef struct {
    logic [71:0] w;
    bit done;
    bit err;
    logic [2:0] code;
    logic [15:0] flen;
    logic [31:0] good;
    logic [31:0] bad;
  } vec_t;

  xgmii_rx_checker dut (
    .clk(clk),
    .i_rst_n(rst_n),
    .i_rx_data(rx_data),
    .i_rx_ctrl(rx_ctrl),
    .o_frame_done(frame_done),
    .o_frame_len(frame_len),
    .o_err(err),
    .o_err_code(err_code),
    .o_in_frame(in_frame),
    .o_good_cnt(good_cnt),
    .o_bad_cnt(bad_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [71:0] w_idle();
    return {8'hFF, {8{IC}}};
  endfunction
  function automatic logic [71:0] w_start();
    return {8'h01, {7{DB}}, SC};
  endfunction
  function automatic logic [71:0] w_data();
    return {8'h00, {8{DB}}};
  endfunction
  function automatic logic [71:0] w_term(input int p);
    logic [63:0] d;
    logic [7:0] c;
    for (int i = 0; i < 8; i++) d[8*i+:8] = (i < p) ? DB : (i == p) ? TC : IC;
    c = 8'hFF << p;
    return {c, d};
  endfunction

  // Word kind from the byte list: first matching rule wins, terminate lane found by trying all eight
  function automatic int kind_of(input logic [71:0] w, output int p, output bit mis);
    logic [7:0] b [8];
    logic [7:0] c;
    bit ok;
    c = w[71:64];
    for (int i = 0; i < 8; i++) b[i] = w[8*i+:8];
    p = 0;
    mis = 1'b0;
    ok = (c == 8'hFF);
    for (int i = 0; i < 8; i++) ok = ok && (b[i] == IC);
    if (ok) return K_IDLE;
    if (c == 8'h01 && b[0] == SC) begin
      for (int i = 1; i < 8; i++) mis = mis || (b[i] != DB);
      return K_START;
    end
    if (c == 8'h00) begin
      for (int i = 0; i < 8; i++) mis = mis || (b[i] != DB);
      return K_DATA;
    end
    for (int q = 0; q < 8; q++) begin
      ok = (c == (8'hFF << q)) && (b[q] == TC);
      for (int j = q + 1; j < 8; j++) ok = ok && (b[j] == IC);
      if (ok) begin
        p = q;
        for (int j = 0; j < q; j++) mis = mis || (b[j] != DB);
        return K_TERM;
      end
    end
    return K_BAD;
  endfunction

  task automatic model(input logic [71:0] w);
    int k, p, nl;
    bit mis;
    k = kind_of(w, p, mis);
    mis = mis && PAT_EN;
    m_done = 1'b0;
    m_err = 1'b0;
    if (k == K_START) begin
      if (m_mode == 1) begin
        m_err = 1'b1;
        m_code = 3'd2;
        m_bad++;
      end
      m_mode = 1;
      m_len = 7;
      m_words = 0;
      m_flag = mis;
    end else if (m_mode == 1) begin
      if (k == K_TERM) begin
        nl = m_len + p;
        m_flen = 16'((nl > 65535) ? 65535 : nl);
        m_mode = 0;
        if (m_flag || mis) begin
          m_err = 1'b1;
          m_code = 3'd5;
          m_bad++;
        end else begin
          m_done = 1'b1;
          m_good++;
        end
      end else if (k == K_DATA && m_words < MAXW) begin
        m_len = (m_len + 8 > 65535) ? 65535 : m_len + 8;
        m_words++;
        m_flag = m_flag || mis;
      end else begin
        m_err = 1'b1;
        m_code = (k == K_DATA) ? 3'd4 : 3'd3;
        m_bad++;
        m_mode = 2;
      end
    end else if (m_mode == 2) begin
      if (k == K_IDLE) m_mode = 0;
    end else if (k != K_IDLE) begin
      m_err = 1'b1;
      m_code = 3'd1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [71:0] w);
    @(negedge clk);
    rx_ctrl = w[71:64];
    rx_data = w[63:0];
    @(posedge clk);
    #1;
    model(w);
    chk("frame_done", {31'd0, frame_done}, {31'd0, m_done});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("err_code", {29'd0, err_code}, {29'd0, m_code});
    chk("frame_len", {16'd0, frame_len}, {16'd0, m_flen});
    chk("in_frame", {31'd0, in_frame}, (m_mode == 1) ? 32'd1 : 32'd0);
    chk("good_cnt", good_cnt, m_good);
    chk("bad_cnt", bad_cnt, m_bad);
    chk("done_err_excl", {31'd0, frame_done & err}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_ctrl = 8'hFF;
    rx_data = {8{IC}};
    rst_n = 1'b0;
    #1;
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_code", {29'd0, err_code}, 32'd0);
    chk("rst_frame_len", {16'd0, frame_len}, 32'd0);
    chk("rst_in_frame", {31'd0, in_frame}, 32'd0);
    chk("rst_good_cnt", good_cnt, 32'd0);
    chk("rst_bad_cnt", bad_cnt, 32'd0);
    m_mode = 0;
    m_len = 0;
    m_words = 0;
    m_flag = 1'b0;
    m_done = 1'b0;
    m_err = 1'b0;
    m_code = '0;
    m_flen = '0;
    m_good = '0;
    m_bad = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [71:0] rand_word();
    int r, lane;
    logic [71:0] w;
    r = int'($urandom_range(99));
    if (r < 20) w = w_idle();
    else if (r < 30) w = w_start();
    else if (r < 65) w = w_data();
    else if (r < 80) w = w_term(int'($urandom_range(7)));
    else if (r < 90) begin
      w = r[0] ? w_data() : w_start();
      lane = int'($urandom_range(7, 1));
      w[8*lane+:8] = 8'($urandom);
    end else w = {8'($urandom), $urandom, $urandom};
    return w;
  endfunction

  initial begin
    vec_t vt [7];
    logic [71:0] w;
    vt[0] = '{w_idle(), 1'b0, 1'b0, 3'd0, 16'd0, 32'd0, 32'd0};
    vt[1] = '{w_idle(), 1'b0, 1'b0, 3'd0, 16'd0, 32'd0, 32'd0};
    vt[2] = '{w_idle(), 1'b0, 1'b0, 3'd0, 16'd0, 32'd0, 32'd0};
    vt[3] = '{w_start(), 1'b0, 1'b0, 3'd0, 16'd0, 32'd0, 32'd0};
    vt[4] = '{w_data(), 1'b0, 1'b0, 3'd0, 16'd0, 32'd0, 32'd0};
    vt[5] = '{w_data(), 1'b0, 1'b0, 3'd0, 16'd0, 32'd0, 32'd0};
    vt[6] = '{w_term(3), 1'b1, 1'b0, 3'd0, 16'd26, 32'd1, 32'd0};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(vt[i].w);
      chk($sformatf("tbl%0d_done", i), {31'd0, frame_done}, {31'd0, vt[i].done});
      chk($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, vt[i].err});
      chk($sformatf("tbl%0d_code", i), {29'd0, err_code}, {29'd0, vt[i].code});
      chk($sformatf("tbl%0d_len", i), {16'd0, frame_len}, {16'd0, vt[i].flen});
      chk($sformatf("tbl%0d_good", i), good_cnt, vt[i].good);
      chk($sformatf("tbl%0d_bad", i), bad_cnt, vt[i].bad);
    end
    do_reset();
    step(w_start());
    step(w_term(0));
    chk("min_done", {31'd0, frame_done}, 32'd1);
    chk("min_len", {16'd0, frame_len}, 32'd7);
    chk("min_good", good_cnt, 32'd1);
    do_reset();
    step(w_start());
    step(w_data());
    step(w_start());
    chk("restart_err", {31'd0, err}, 32'd1);
    chk("restart_code", {29'd0, err_code}, 32'd2);
    chk("restart_bad", bad_cnt, 32'd1);
    step(w_term(7));
    chk("restart_done", {31'd0, frame_done}, 32'd1);
    chk("restart_len", {16'd0, frame_len}, 32'd14);
    chk("restart_good", good_cnt, 32'd1);
    chk("restart_bad2", bad_cnt, 32'd1);
    do_reset();
    step(w_start());
    step(w_idle());
    chk("ctrl_err", {31'd0, err}, 32'd1);
    chk("ctrl_code", {29'd0, err_code}, 32'd3);
    chk("ctrl_bad", bad_cnt, 32'd1);
    step(w_data());
    chk("drop_data_err", {31'd0, err}, 32'd0);
    step(w_idle());
    chk("drop_idle_err", {31'd0, err}, 32'd0);
    chk("drop_idle_in_frame", {31'd0, in_frame}, 32'd0);
    chk("drop_code_held", {29'd0, err_code}, 32'd3);
    do_reset();
    step(w_start());
    for (int i = 0; i < MAXW; i++) step(w_data());
    chk("max_no_err", {31'd0, err}, 32'd0);
    chk("max_in_frame", {31'd0, in_frame}, 32'd1);
    step(w_data());
    chk("oversize_err", {31'd0, err}, 32'd1);
    chk("oversize_code", {29'd0, err_code}, 32'd4);
    chk("oversize_bad", bad_cnt, 32'd1);
    chk("oversize_in_frame", {31'd0, in_frame}, 32'd0);
    do_reset();
    step(w_start());
    w = w_data();
    w[39:32] = 8'h55;
    step(w);
    step(w_term(2));
    chk("pat_len", {16'd0, frame_len}, 32'd17);
`ifdef XGMII_RX_PATTERN_CHECK_EN
    chk("pat_err", {31'd0, err}, 32'd1);
    chk("pat_code", {29'd0, err_code}, 32'd5);
    chk("pat_bad", bad_cnt, 32'd1);
`else
    chk("pat_done", {31'd0, frame_done}, 32'd1);
    chk("pat_good", good_cnt, 32'd1);
    chk("pat_bad", bad_cnt, 32'd0);
`endif
    do_reset();
    step(w_start());
    step(w_data());
    do_reset();
    step(w_term(0));
    chk("midrst_err", {31'd0, err}, 32'd1);
    chk("midrst_code", {29'd0, err_code}, 32'd1);
    chk("midrst_good", good_cnt, 32'd0);
    chk("midrst_bad", bad_cnt, 32'd0);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(399) == 0) do_reset();
      else step(rand_word());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
